// File: rtl/trans_assembler.sv
// trans_assembler
// Builds 128-bit transactions from a byte stream. A frame is 16 payload
// bytes (byte 0 first, flagged by sof_i, most significant byte first)
// followed by one checksum byte equal to the XOR of the payload. A frame
// is emitted as a single-cycle valid_o strobe once its checksum is good
// (or ignored when CHECK_EN=0) and its sender and receiver ids differ.
//
// Ports
//   clk           : clock, rising edge
//   rst_n         : asynchronous active-low reset
//   byte_i        : inbound byte
//   byte_valid_i  : byte_i / sof_i qualifier
//   sof_i         : byte_i is byte 0 of a frame
//   byte_ready_o  : byte accepted this cycle when high together with byte_valid_i
//   data_o        : assembled word {sender[47:0], receiver[47:0], amount[21:0], blk_start, rsvd[8:0]}
//   valid_o       : one-cycle strobe qualifying data_o
//   frame_cnt_o   : frames emitted (saturating)
//   err_cnt_o     : dropped frames plus stray bytes (saturating)
module trans_assembler #(
  parameter int CHECK_EN = 1,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       byte_i,
  input  logic             byte_valid_i,
  input  logic             sof_i,
  output logic             byte_ready_o,
  output logic [127:0]     data_o,
  output logic             valid_o,
  output logic [CNT_W-1:0] frame_cnt_o,
  output logic [CNT_W-1:0] err_cnt_o
);

  typedef enum logic [1:0] {IDLE, PAYLOAD, CHECKSUM, EMIT} state_t;

  state_t             state_q, state_d;
  logic [3:0]         idx_q, idx_d;
  logic [7:0]         xor_q, xor_d;
  logic [127:0]       data_q, data_d;
  logic               valid_q, valid_d;
  logic [CNT_W-1:0]   frame_cnt_q, frame_cnt_d;
  logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;

  logic               accept;
  logic [6:0]         wr_pos;
  logic               ids_differ;
  logic               chk_ok;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Ready is a pure function of the state register so there is no
  // combinational path from the byte inputs back to byte_ready_o.
  assign byte_ready_o = (state_q != EMIT);
  assign accept       = byte_valid_i & byte_ready_o;

  // Byte n lands at bits [127-8n -: 8]; ~idx is 15-idx for a 4-bit index.
  assign wr_pos       = {~idx_q, 3'b000};
  assign ids_differ   = (data_q[127:80] != data_q[79:32]);
  assign chk_ok       = (CHECK_EN == 0) || (byte_i == xor_q);

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    xor_d       = xor_q;
    data_d      = data_q;
    valid_d     = 1'b0;
    frame_cnt_d = frame_cnt_q;
    err_cnt_d   = err_cnt_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          if (sof_i) begin
            data_d[127:120] = byte_i;
            xor_d           = byte_i;
            idx_d           = 4'd1;
            state_d         = PAYLOAD;
          end else begin
            err_cnt_d = sat_inc(err_cnt_q);
          end
        end
      end

      PAYLOAD: begin
        if (accept) begin
          if (sof_i) begin
            // Abort the current frame and restart with this byte as byte 0.
            err_cnt_d       = sat_inc(err_cnt_q);
            data_d[127:120] = byte_i;
            xor_d           = byte_i;
            idx_d           = 4'd1;
          end else begin
            data_d[wr_pos +: 8] = byte_i;
            xor_d               = xor_q ^ byte_i;
            idx_d               = idx_q + 4'd1;
            if (idx_q == 4'd15) state_d = CHECKSUM;
          end
        end
      end

      CHECKSUM: begin
        if (accept) begin
          if (sof_i) begin
            err_cnt_d       = sat_inc(err_cnt_q);
            data_d[127:120] = byte_i;
            xor_d           = byte_i;
            idx_d           = 4'd1;
            state_d         = PAYLOAD;
          end else if (chk_ok && ids_differ) begin
            // valid_o is registered, so it rises together with the EMIT state.
            valid_d = 1'b1;
            state_d = EMIT;
          end else begin
            err_cnt_d = sat_inc(err_cnt_q);
            state_d   = IDLE;
          end
        end
      end

      EMIT: begin
        frame_cnt_d = sat_inc(frame_cnt_q);
        state_d     = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= 4'd0;
      xor_q       <= 8'd0;
      data_q      <= 128'd0;
      valid_q     <= 1'b0;
      frame_cnt_q <= '0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      xor_q       <= xor_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      frame_cnt_q <= frame_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign data_o      = data_q;
  assign valid_o     = valid_q;
  assign frame_cnt_o = frame_cnt_q;
  assign err_cnt_o   = err_cnt_q;

endmodule

// File: tb/tb_trans_assembler.sv
// Directed bench for trans_assembler. Two instances share the stimulus:
// dut (CHECK_EN=1, CNT_W=16) and dut0 (CHECK_EN=0, CNT_W=2, to reach
// counter saturation quickly).
module tb_trans_assembler;

  logic         clk;
  logic         rst_n;
  logic [7:0]   byte_v;
  logic         vld;
  logic         sof;

  logic         ready, ready0;
  logic [127:0] data, data0;
  logic         valid, valid0;
  logic [15:0]  fcnt, ecnt;
  logic [1:0]   fcnt0, ecnt0;

  int ntests = 0;
  int nfail  = 0;
  int vcnt   = 0;
  int vcnt0  = 0;
  int v_base, v0_base;

  localparam logic [127:0] W1 = 128'h0000_0000_0001_0000_0000_0002_0000_CA00;
  localparam logic [7:0]   W1_XOR = 8'hC9;
  localparam logic [127:0] W2 = {48'h1234_5678_9ABC, 48'h0F0E_0D0C_0B0A, 22'd1000, 1'b0, 9'd0};
  localparam logic [127:0] W3 = {48'hABCD_EF01_2345, 48'hABCD_EF01_2345, 22'd7, 1'b1, 9'd0};

  trans_assembler #(.CHECK_EN(1), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .byte_i(byte_v), .byte_valid_i(vld), .sof_i(sof),
    .byte_ready_o(ready), .data_o(data), .valid_o(valid),
    .frame_cnt_o(fcnt), .err_cnt_o(ecnt)
  );

  trans_assembler #(.CHECK_EN(0), .CNT_W(2)) dut0 (
    .clk(clk), .rst_n(rst_n), .byte_i(byte_v), .byte_valid_i(vld), .sof_i(sof),
    .byte_ready_o(ready0), .data_o(data0), .valid_o(valid0),
    .frame_cnt_o(fcnt0), .err_cnt_o(ecnt0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (valid)  vcnt  <= vcnt + 1;
    if (valid0) vcnt0 <= vcnt0 + 1;
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] calc_xor(input logic [127:0] w);
    logic [7:0] x;
    x = 8'd0;
    for (int i = 0; i < 16; i++) x = x ^ w[127-8*i -: 8];
    return x;
  endfunction

  // Drive one byte from a falling edge; wait (bounded) while the DUT is in EMIT.
  task automatic send(input logic [7:0] b, input logic s);
    int n;
    n = 0;
    @(negedge clk);
    while (!ready && n < 20) begin
      vld = 1'b0;
      @(negedge clk);
      n++;
    end
    if (n >= 20) check("ready_timeout", {127'd0, ready}, 128'd1);
    byte_v = b;
    sof    = s;
    vld    = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      vld = 1'b0;
      sof = 1'b0;
    end
  endtask

  // Full frame; checksum is ck. gap>0 inserts idle cycles after byte 8 and before the checksum.
  task automatic send_frame(input logic [127:0] w, input logic [7:0] ck, input int gap);
    for (int i = 0; i < 16; i++) begin
      send(w[127-8*i -: 8], i == 0);
      if (gap > 0 && i == 8) idle(gap);
    end
    if (gap > 0) idle(gap);
    send(ck, 1'b0);
  endtask

  task automatic do_reset;
    @(negedge clk);
    vld   = 1'b0;
    sof   = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n  = 1'b0;
    vld    = 1'b0;
    sof    = 1'b0;
    byte_v = 8'd0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_ready", {127'd0, ready}, 128'd1);
    check("rst_valid", {127'd0, valid}, 128'd0);
    check("rst_data", data, 128'd0);
    check("rst_fcnt", {112'd0, fcnt}, 128'd0);
    check("rst_ecnt", {112'd0, ecnt}, 128'd0);
    rst_n = 1'b1;

    // Good frame, back-to-back, hand-computed checksum
    send_frame(W1, W1_XOR, 0);
    @(negedge clk); vld = 1'b0;
    check("good_valid", {127'd0, valid}, 128'd1);
    check("good_data", data, W1);
    check("good_ready_emit", {127'd0, ready}, 128'd0);
    @(negedge clk);
    check("good_valid_1cyc", {127'd0, valid}, 128'd0);
    check("good_fcnt", {112'd0, fcnt}, 128'd1);
    check("good_ecnt", {112'd0, ecnt}, 128'd0);
    check("good_data_hold", data, W1);

    // Bad checksum, then a good frame
    do_reset;
    v_base = vcnt;
    send_frame(W2, calc_xor(W2) ^ 8'h01, 0);
    idle(3);
    check("badck_novalid", vcnt - v_base, 0);
    check("badck_ecnt", {112'd0, ecnt}, 128'd1);
    check("badck_fcnt", {112'd0, fcnt}, 128'd0);
    send_frame(W2, calc_xor(W2), 0);
    @(negedge clk); vld = 1'b0;
    check("badck_next_valid", {127'd0, valid}, 128'd1);
    check("badck_next_data", data, W2);
    idle(2);
    check("badck_next_fcnt", {112'd0, fcnt}, 128'd1);

    // sof on payload byte 7: abort and restart
    do_reset;
    v_base = vcnt;
    for (int i = 0; i < 7; i++) send(W2[127-8*i -: 8], i == 0);
    send_frame(W1, W1_XOR, 0);
    @(negedge clk); vld = 1'b0;
    check("abort_valid", {127'd0, valid}, 128'd1);
    check("abort_data", data, W1);
    idle(3);
    check("abort_ecnt", {112'd0, ecnt}, 128'd1);
    check("abort_pulses", vcnt - v_base, 1);
    check("abort_fcnt", {112'd0, fcnt}, 128'd1);

    // Stray bytes in IDLE, then saturation of the 2-bit counter in dut0
    do_reset;
    v_base = vcnt;
    send(8'h11, 1'b0);
    send(8'h22, 1'b0);
    send(8'h33, 1'b0);
    idle(2);
    check("stray_ecnt", {112'd0, ecnt}, 128'd3);
    check("stray_ready", {127'd0, ready}, 128'd1);
    check("stray_novalid", vcnt - v_base, 0);
    send(8'h44, 1'b0);
    send(8'h55, 1'b0);
    idle(2);
    check("stray_ecnt5", {112'd0, ecnt}, 128'd5);
    check("sat_ecnt0", {126'd0, ecnt0}, 128'd3);

    // Equal ids dropped; CHECK_EN=0 emits despite wrong checksum
    do_reset;
    v_base  = vcnt;
    v0_base = vcnt0;
    send_frame(W3, calc_xor(W3), 0);
    idle(3);
    check("sameid_ecnt", {112'd0, ecnt}, 128'd1);
    check("sameid_ecnt0", {126'd0, ecnt0}, 128'd1);
    check("sameid_novalid", vcnt - v_base, 0);
    check("sameid_novalid0", vcnt0 - v0_base, 0);
    send_frame(W2, calc_xor(W2) ^ 8'h55, 0);
    @(negedge clk); vld = 1'b0;
    check("nochk_valid0", {127'd0, valid0}, 128'd1);
    check("nochk_data0", data0, W2);
    check("nochk_dut_valid", {127'd0, valid}, 128'd0);
    idle(2);
    check("nochk_fcnt0", {126'd0, fcnt0}, 128'd1);
    check("nochk_dut_ecnt", {112'd0, ecnt}, 128'd2);

    // Reset mid-frame after byte 10, then a full good frame
    do_reset;
    v_base = vcnt;
    for (int i = 0; i < 11; i++) send(W2[127-8*i -: 8], i == 0);
    @(negedge clk);
    vld   = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midrst_ready", {127'd0, ready}, 128'd1);
    @(negedge clk);
    rst_n = 1'b1;
    check("midrst_ready_after", {127'd0, ready}, 128'd1);
    send_frame(W1, W1_XOR, 0);
    idle(3);
    check("midrst_pulses", vcnt - v_base, 1);
    check("midrst_ecnt", {112'd0, ecnt}, 128'd0);
    check("midrst_fcnt", {112'd0, fcnt}, 128'd1);
    check("midrst_data", data, W1);

    // Idle gaps inside a frame do not abort it
    do_reset;
    v_base = vcnt;
    send_frame(W2, calc_xor(W2), 4);
    @(negedge clk); vld = 1'b0;
    check("gap_valid", {127'd0, valid}, 128'd1);
    check("gap_data", data, W2);
    idle(2);
    check("gap_ecnt", {112'd0, ecnt}, 128'd0);
    check("gap_pulses", vcnt - v_base, 1);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
